// File: rtl/demux_1x2_buffered_seq_pkg.sv
// Shared definitions for the 1-to-2 buffered distributor: destination masks and
// FIFO pointer sizing helper.
package demux_1x2_buffered_seq_pkg;

    localparam int unsigned NUM_BRANCHES = 2;

    // Destination mask: bit0 selects the low branch, bit1 the high branch.
    localparam logic [1:0] DST_NONE  = 2'b00;
    localparam logic [1:0] DST_LOW   = 2'b01;
    localparam logic [1:0] DST_HIGH  = 2'b10;
    localparam logic [1:0] DST_BCAST = 2'b11;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/demux_branch_fifo.sv
// First-word-fall-through register FIFO for one distributor branch; the head
// reads as zero while the FIFO is empty.
module demux_branch_fifo
    import demux_1x2_buffered_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // Guards keep the FIFO consistent even if a caller ignores full/empty.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/demux_1x2_buffered_seq.sv
// Registered 1-to-2 distributor: steers each accepted word to the low branch,
// the high branch, both or neither, each branch buffered by its own FIFO.
module demux_1x2_buffered_seq
    import demux_1x2_buffered_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned COMMAND_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_valid,
    input  logic [DATA_WIDTH-1:0]           i_data_bus,
    input  logic [COMMAND_WIDTH-1:0]        i_cmd,
    input  logic                            i_en,
    output logic                            o_ready,
    output logic [NUM_BRANCHES-1:0]         o_valid,
    output logic [NUM_BRANCHES*DATA_WIDTH-1:0] o_data_bus,
    input  logic [NUM_BRANCHES-1:0]         i_ready
);

    logic [NUM_BRANCHES-1:0] push, pop, full, empty;
    logic [DATA_WIDTH-1:0]   head [NUM_BRANCHES];
    logic                    accept;

    // Broadcast stays atomic because any full targeted branch blocks the word.
    // rst_n gating holds o_ready low for the whole reset window.
    assign o_ready = rst_n & i_en
                   & ~(i_cmd[0] & full[0])
                   & ~(i_cmd[1] & full[1]);
    assign accept  = i_valid & o_ready;

    assign push[0] = accept & ((i_cmd & DST_LOW)  != DST_NONE);
    assign push[1] = accept & ((i_cmd & DST_HIGH) != DST_NONE);

    for (genvar b = 0; b < NUM_BRANCHES; b++) begin : g_branch
        assign pop[b]     = ~empty[b] & i_ready[b];
        assign o_valid[b] = ~empty[b];
        assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = head[b];

        demux_branch_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[b]),
            .push_data (i_data_bus),
            .pop       (pop[b]),
            .head_data (head[b]),
            .full      (full[b]),
            .empty     (empty[b])
        );
    end

endmodule
